alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_muldiv.sv | 87 ++++++++
 rtl/alu_seq.sv | 117 +++++++++++
 tb/tb_alu_seq.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM state
// encodings and the multiply/divide operation select.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;
  localparam logic [3:0] ALU_DIVU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_REMU = 4'b1101;

  typedef logic [1:0] alu_state_t;
  localparam alu_state_t ST_IDLE = 2'd0;
  localparam alu_state_t ST_CALC = 2'd1;
  localparam alu_state_t ST_DONE = 2'd2;

  typedef logic [1:0] md_op_t;
  localparam md_op_t MD_MUL  = 2'd0;
  localparam md_op_t MD_DIVU = 2'd1;
  localparam md_op_t MD_REMU = 2'd2;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  function automatic md_op_t md_op_of(input logic [3:0] op);
    md_op_t sel;
    case (op)
      ALU_DIVU: sel = MD_DIVU;
      ALU_REMU: sel = MD_REMU;
      default:  sel = MD_MUL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation request / result handshake bundle between a producer and alu_seq.
interface alu_seq_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] di1;
  logic [WIDTH-1:0] di2;
  logic [3:0]       alu_ctr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, di1, di2, alu_ctr, out_ready,
    input  in_ready, out_valid, out, zero, ovf, busy
  );

  modport slave (
    input  in_valid, di1, di2, alu_ctr, out_ready,
    output in_ready, out_valid, out, zero, ovf, busy
  );

endinterface

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// The first step is applied on the start edge, so done rises WIDTH cycles later.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic             running;
  logic [CW-1:0]    cnt;
  md_op_t           op_r;
  // acc: product / partial remainder; sh: multiplicand / dividend-then-quotient;
  // opd: multiplier / divisor
  logic [WIDTH-1:0] r_acc, r_sh, r_opd;
  logic [WIDTH-1:0] s_acc, s_sh, s_opd;
  logic [WIDTH-1:0] n_acc, n_sh, n_opd;
  logic [WIDTH:0]   trial;
  md_op_t           s_op;

  always_comb begin
    s_op  = start ? op : op_r;
    s_acc = start ? '0 : r_acc;
    s_sh  = start ? a  : r_sh;
    s_opd = start ? b  : r_opd;
    trial = '0;
    n_acc = s_acc;
    n_sh  = s_sh;
    n_opd = s_opd;
    if (s_op == MD_MUL) begin
      if (s_opd[0]) n_acc = s_acc + s_sh;
      n_sh  = s_sh << 1;
      n_opd = s_opd >> 1;
    end else begin
      // A zero divisor never borrows, giving all-ones quotient and remainder = a.
      trial = {s_acc, s_sh[WIDTH-1]} - {1'b0, s_opd};
      if (!trial[WIDTH]) begin
        n_acc = trial[WIDTH-1:0];
        n_sh  = {s_sh[WIDTH-2:0], 1'b1};
      end else begin
        n_acc = {s_acc[WIDTH-2:0], s_sh[WIDTH-1]};
        n_sh  = {s_sh[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      op_r    <= MD_MUL;
      r_acc   <= '0;
      r_sh    <= '0;
      r_opd   <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= CW'(WIDTH - 1);
      op_r    <= op;
      r_acc   <= n_acc;
      r_sh    <= n_sh;
      r_opd   <= n_opd;
    end else if (running) begin
      if (cnt == '0) begin
        running <= 1'b0;
      end else begin
        cnt   <= cnt - 1'b1;
        r_acc <= n_acc;
        r_sh  <= n_sh;
        r_opd <= n_opd;
      end
    end
  end

  assign done   = running && (cnt == '0);
  assign result = (op_r == MD_DIVU) ? r_sh : r_acc;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIVU/REMU,
// with a valid/ready request side and a held result until consumed.
//   state   | meaning
//   IDLE    | ready for a new operation
//   CALC    | multiply/divide iterating in alu_muldiv
//   DONE    | result valid, waiting for out_ready
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  alu_state_t       state;
  logic [WIDTH-1:0] out_r;
  logic             zero_r;
  logic             ovf_r;
  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic [WIDTH-1:0] a, b, sum, diff, alu_res;
  logic [SHW-1:0]   shamt;
  logic             alu_ovf;

  assign a      = bus.di1;
  assign b      = bus.di2;
  assign shamt  = b[SHW-1:0];
  assign sum    = a + b;
  assign diff   = a - b;
  assign accept = bus.in_valid && (state == ST_IDLE);
  assign md_start = accept && is_muldiv(bus.alu_ctr);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.alu_ctr)
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_NOR:  alu_res = ~(a | b);
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL:  alu_res = a << shamt;
      ALU_SRL:  alu_res = a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (md_op_of(bus.alu_ctr)),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      out_r  <= '0;
      zero_r <= 1'b1;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_muldiv(bus.alu_ctr)) begin
              state <= ST_CALC;
            end else begin
              state  <= ST_DONE;
              out_r  <= alu_res;
              zero_r <= (alu_res == '0);
              ovf_r  <= alu_ovf;
            end
          end
        end
        ST_CALC: begin
          if (md_done) begin
            state  <= ST_DONE;
            out_r  <= md_result;
            zero_r <= (md_result == '0);
            ovf_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state == ST_CALC);
  assign bus.out       = out_r;
  assign bus.zero      = zero_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] r_out;
  logic        r_zero, r_ovf;
  int          r_lat, r_busy;

  // Issue one operation, wait for the result, record it, then consume it.
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    bus.in_valid = 1'b1;
    bus.alu_ctr  = op;
    bus.di1      = x;
    bus.di2      = y;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    r_lat  = 1;
    r_busy = 0;
    while (!bus.out_valid && r_lat < 100) begin
      if (bus.busy) r_busy++;
      @(posedge clk); #1; r_lat++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout op=%h: out_valid=%b expected 1", op, bus.out_valid);
    end
    r_out  = bus.out;
    r_zero = bus.zero;
    r_ovf  = bus.ovf;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", bus.out); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", bus.zero); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_cycle();
    logic [3:0]  ops [15] = '{ALU_ADD, ALU_SUB, ALU_SUB, ALU_SLTU, ALU_SLT, ALU_SRA, ALU_SRL,
                              ALU_SLL, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, 4'b1110, 4'b1111, ALU_ADD};
    logic [31:0] va  [15] = '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h80000000, 32'h80000000, 32'h00000001, 32'hF0F01234, 32'hF0000000,
                              32'hA5A5A5A5, 32'h0, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF};
    logic [31:0] vb  [15] = '{32'h1, 32'd5, 32'h1, 32'h1, 32'h1, 32'h21, 32'h21, 32'h24,
                              32'h0FF0FFFF, 32'h0000000F, 32'hFFFF0000, 32'h0, 32'h1, 32'h1, 32'h1};
    logic [31:0] eo  [15] = '{32'h80000000, 32'h0, 32'h7FFFFFFF, 32'h0, 32'h1, 32'hC0000000,
                              32'h40000000, 32'h10, 32'h00F01234, 32'hF000000F, 32'h5A5AA5A5,
                              32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
    logic        ez  [15] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic        ev  [15] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 15; i++) begin
      run_op(ops[i], va[i], vb[i]);
      checks++; if (r_out !== eo[i]) begin errors++; $display("FAIL single[%0d]_out: got %h expected %h", i, r_out, eo[i]); end
      checks++; if (r_zero !== ez[i]) begin errors++; $display("FAIL single[%0d]_zero: got %b expected %b", i, r_zero, ez[i]); end
      checks++; if (r_ovf !== ev[i]) begin errors++; $display("FAIL single[%0d]_ovf: got %b expected %b", i, r_ovf, ev[i]); end
      checks++; if (r_lat != 1) begin errors++; $display("FAIL single[%0d]_latency: got %0d expected 1", i, r_lat); end
    end
  endtask

  task automatic test_muldiv();
    logic [3:0]  ops [9] = '{ALU_MUL, ALU_MUL, ALU_MUL, ALU_DIVU, ALU_REMU, ALU_DIVU, ALU_REMU,
                             ALU_DIVU, ALU_REMU};
    logic [31:0] va  [9] = '{32'h10000, 32'd7, 32'hFFFFFFFF, 32'd100, 32'd100, 32'h12345678,
                             32'd9, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vb  [9] = '{32'h10001, 32'd6, 32'hFFFFFFFF, 32'd7, 32'd7, 32'h0, 32'h0,
                             32'h10, 32'h10};
    logic [31:0] eo  [9] = '{32'h00010000, 32'd42, 32'h1, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd9,
                             32'h0FFFFFFF, 32'hF};
    for (int i = 0; i < 9; i++) begin
      run_op(ops[i], va[i], vb[i]);
      checks++; if (r_out !== eo[i]) begin errors++; $display("FAIL muldiv[%0d]_out: got %h expected %h", i, r_out, eo[i]); end
      checks++; if (r_lat != 33) begin errors++; $display("FAIL muldiv[%0d]_latency: got %0d expected 33", i, r_lat); end
      checks++; if (r_busy != 32) begin errors++; $display("FAIL muldiv[%0d]_busy_cycles: got %0d expected 32", i, r_busy); end
      checks++; if (r_ovf !== 1'b0) begin errors++; $display("FAIL muldiv[%0d]_ovf: got %b expected 0", i, r_ovf); end
    end
    run_op(ALU_DIVU, 32'd3, 32'd5);
    checks++; if (r_zero !== 1'b1) begin errors++; $display("FAIL divu_zero_flag: got %b expected 1", r_zero); end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    bus.alu_ctr   = ALU_ADD;
    bus.di1       = 32'd1;
    bus.di2       = 32'd2;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp_v = (i % 2 == 0);
      checks++; if (bus.out_valid !== exp_v) begin errors++; $display("FAIL b2b[%0d]_out_valid: got %b expected %b", i, bus.out_valid, exp_v); end
      checks++; if (bus.in_ready !== !exp_v) begin errors++; $display("FAIL b2b[%0d]_in_ready: got %b expected %b", i, bus.in_ready, !exp_v); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (bus.out !== 32'd3) begin errors++; $display("FAIL b2b_out: got %h expected 3", bus.out); end
  endtask

  task automatic test_backpressure();
    bus.alu_ctr  = ALU_ADD;
    bus.di1      = 32'd10;
    bus.di2      = 32'd20;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.di1 = 32'd100;
    bus.di2 = 32'd200;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp[%0d]_out_valid: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.out !== 32'd30) begin errors++; $display("FAIL bp[%0d]_out: got %h expected 1e", i, bus.out); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp[%0d]_in_ready: got %b expected 0", i, bus.in_ready); end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_consumed_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out !== 32'd30) begin errors++; $display("FAIL bp_out_hold: got %h expected 1e", bus.out); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_queue[%0d]: out_valid got %b expected 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen = 0;
    bus.alu_ctr  = ALU_MUL;
    bus.di1      = 32'd3;
    bus.di2      = 32'd5;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b expected 1", bus.busy); end
    rst_n = 1'b0;
    #2;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out !== 32'h0) begin errors++; $display("FAIL rst_mid_out: got %h expected 0", bus.out); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL rst_mid_zero: got %b expected 1", bus.zero); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 1", bus.in_ready); end
    #3;
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_aborted: active cycles got %0d expected 0", seen); end
    run_op(ALU_ADD, 32'd2, 32'd3);
    checks++; if (r_out !== 32'd5) begin errors++; $display("FAIL rst_mid_next_op: got %h expected 5", r_out); end
    checks++; if (r_lat != 1) begin errors++; $display("FAIL rst_mid_next_latency: got %0d expected 1", r_lat); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.di1       = '0;
    bus.di2       = '0;
    bus.alu_ctr   = '0;
    test_reset();
    test_single_cycle();
    test_muldiv();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
